exc_ctrl: RTL and testbench

Exception sequencer for the 54-instruction pipelined CPU: the requesting side of the CP0 trap interface. It watches the decode stage for syscall, break, teq-taken and eret, then raises `exception`/`eret` with cause and PC to CP0. It freezes and flushes the pipeline, and redirects fetch to the handler vector or to the return address read back from CP0's EPC. It sits between the decode stage, the PC mux and CP0.

---
 rtl/exc_if.sv | 38 +++
 rtl/exc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_if.sv
// Decode/CP0 side of the exception sequencer.
// master: the sequencer (drives trap requests and pipeline control).
// slave : the surrounding pipeline and CP0 (drive decode info and CP0 registers).
interface exc_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        is_syscall;
    logic        is_break;
    logic        is_teq;
    logic        is_eret;
    logic        teq_eq;
    logic [31:0] status;
    logic [31:0] epc;

    logic        exception;
    logic        eret;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        in_handler;

    modport master (
        input  id_valid, id_pc, is_syscall, is_break, is_teq, is_eret, teq_eq,
               status, epc,
        output exception, eret, cause, pc, stall, flush, redirect, redirect_pc,
               in_handler
    );

    modport slave (
        output id_valid, id_pc, is_syscall, is_break, is_teq, is_eret, teq_eq,
               status, epc,
        input  exception, eret, cause, pc, stall, flush, redirect, redirect_pc,
               in_handler
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception sequencer: requests traps/returns from CP0, freezes and flushes
// the pipeline, then redirects fetch to the handler or to EPC + 4.
// Optional build macro EXC_STATUS_MASK_EN: gate traps with CP0 status
// (bit 0 global enable, bits 1/2/3 syscall/break/teq enables).
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    exc_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAISE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RET
    } state_t;

    localparam logic [3:0] CAUSE_SYS  = 4'd8;
    localparam logic [3:0] CAUSE_BRK  = 4'd9;
    localparam logic [3:0] CAUSE_TEQ  = 4'd13;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ret_q, ret_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;
    logic        exception_q, exception_d;
    logic        eret_q, eret_d;
    logic        stall_q, stall_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic        in_handler_q, in_handler_d;

    logic        trap_sys, trap_brk, trap_teq, trap;
    logic [3:0]  trap_cause;
    logic        unused_status;

    assign unused_status = ^bus.status;

    // Decode which trap (if any) the decode-stage instruction raises, highest priority first
    always_comb begin
        trap_sys   = 1'b0;
        trap_brk   = 1'b0;
        trap_teq   = 1'b0;
        trap_cause = 4'd0;
`ifdef EXC_STATUS_MASK_EN
        trap_sys = bus.id_valid & bus.is_syscall & bus.status[0] & bus.status[1];
        trap_brk = bus.id_valid & bus.is_break   & bus.status[0] & bus.status[2];
        trap_teq = bus.id_valid & bus.is_teq & bus.teq_eq & bus.status[0] & bus.status[3];
`else
        trap_sys = bus.id_valid & bus.is_syscall;
        trap_brk = bus.id_valid & bus.is_break;
        trap_teq = bus.id_valid & bus.is_teq & bus.teq_eq;
`endif
        if (trap_sys)      trap_cause = CAUSE_SYS;
        else if (trap_brk) trap_cause = CAUSE_BRK;
        else if (trap_teq) trap_cause = CAUSE_TEQ;
        trap = trap_sys | trap_brk | trap_teq;
    end

    // Next-state logic; outputs are decoded from the next state so they are registered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    state_d = S_RAISE;
                    ret_d   = 1'b0;
                    cause_d = trap_cause;
                    pc_d    = bus.id_pc + 32'd4;
                end
            end
            S_RAISE, S_RET: begin
                state_d = S_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_REDIRECT;
                    rpc_d   = ret_q ? (bus.epc + 32'd4) : HANDLER_ADDR;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REDIRECT: begin
                state_d = ret_q ? S_IDLE : S_HANDLER;
            end
            S_HANDLER: begin
                // nested traps are ignored; eret wins over a simultaneous trap
                if (bus.id_valid && bus.is_eret) begin
                    state_d = S_RET;
                    ret_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        exception_d  = (state_d == S_RAISE);
        eret_d       = (state_d == S_RET);
        flush_d      = (state_d == S_FLUSH);
        redirect_d   = (state_d == S_REDIRECT);
        in_handler_d = (state_d == S_HANDLER);
        stall_d      = (state_d == S_RAISE) || (state_d == S_RET) ||
                       (state_d == S_FLUSH) || (state_d == S_REDIRECT);
    end

    // State and output registers; reset aborts any sequence in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            ret_q        <= 1'b0;
            cause_q      <= 4'd0;
            pc_q         <= 32'd0;
            rpc_q        <= 32'd0;
            exception_q  <= 1'b0;
            eret_q       <= 1'b0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ret_q        <= ret_d;
            cause_q      <= cause_d;
            pc_q         <= pc_d;
            rpc_q        <= rpc_d;
            exception_q  <= exception_d;
            eret_q       <= eret_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            in_handler_q <= in_handler_d;
        end
    end

    assign bus.exception   = exception_q;
    assign bus.eret        = eret_q;
    assign bus.cause       = cause_q;
    assign bus.pc          = pc_q;
    assign bus.stall       = stall_q;
    assign bus.flush       = flush_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = rpc_q;
    assign bus.in_handler  = in_handler_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by random decode traffic,
// compared each cycle against a timeline model of the trap/return sequence.
module tb_exc_ctrl;

    localparam int          F       = 2;
    localparam logic [31:0] HANDLER = 32'h00400004;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exc_if bus();

    exc_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: m_pos is the position inside a trap/return sequence
    // (0 = CP0 pulse, 1..F = flush, F+1 = redirect, -1 = none).
    int          m_pos = -1;
    bit          m_ret = 1'b0;
    bit          m_h   = 1'b0;
    logic [3:0]  m_cause = 4'd0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_rpc   = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_ret = 1'b0; m_h = 1'b0;
        m_cause = 4'd0; m_pc = 32'd0; m_rpc = 32'd0;
    endtask

    task automatic trap_of(output logic [3:0] c, output bit acc);
        bit en_s, en_b, en_t;
        en_s = 1'b1; en_b = 1'b1; en_t = 1'b1;
`ifdef EXC_STATUS_MASK_EN
        en_s = bus.status[0] && bus.status[1];
        en_b = bus.status[0] && bus.status[2];
        en_t = bus.status[0] && bus.status[3];
`endif
        acc = 1'b1;
        c   = 4'd0;
        if (bus.id_valid && bus.is_syscall && en_s)                  c = 4'd8;
        else if (bus.id_valid && bus.is_break && en_b)               c = 4'd9;
        else if (bus.id_valid && bus.is_teq && bus.teq_eq && en_t)   c = 4'd13;
        else acc = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] c;
        bit acc;
        if (m_pos >= 0) begin
            if (m_pos == F + 1) begin
                m_pos = -1;
                m_h   = !m_ret;
            end else begin
                m_pos++;
                if (m_pos == F + 1) m_rpc = m_ret ? bus.epc + 32'd4 : HANDLER;
            end
        end else if (m_h) begin
            if (bus.id_valid && bus.is_eret) begin
                m_pos = 0; m_ret = 1'b1; m_h = 1'b0;
            end
        end else begin
            trap_of(c, acc);
            if (acc) begin
                m_pos = 0; m_ret = 1'b0; m_cause = c; m_pc = bus.id_pc + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        chk("exception",   32'(bus.exception),  32'(m_pos == 0 && !m_ret));
        chk("eret",        32'(bus.eret),       32'(m_pos == 0 && m_ret));
        chk("flush",       32'(bus.flush),      32'(m_pos >= 1 && m_pos <= F));
        chk("redirect",    32'(bus.redirect),   32'(m_pos == F + 1));
        chk("stall",       32'(bus.stall),      32'(m_pos >= 0));
        chk("in_handler",  32'(bus.in_handler), 32'(m_h && m_pos < 0));
        chk("cause",       32'(bus.cause),      32'(m_cause));
        chk("pc",          bus.pc,              m_pc);
        chk("redirect_pc", bus.redirect_pc,     m_rpc);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic idle_in();
        bus.id_valid = 1'b0; bus.is_syscall = 1'b0; bus.is_break = 1'b0;
        bus.is_teq = 1'b0; bus.is_eret = 1'b0; bus.teq_eq = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input bit s, input bit b, input bit t,
                         input bit eq, input bit e);
        bus.id_valid = 1'b1; bus.id_pc = a; bus.is_syscall = s; bus.is_break = b;
        bus.is_teq = t; bus.teq_eq = eq; bus.is_eret = e;
        step();
        idle_in();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_in();
        bus.id_pc  = 32'd0;
        bus.status = 32'h0000000F;
        bus.epc    = 32'h00400100;

        // reset values
        #2 check_all();
        @(negedge clk);
        rst = 1'b0;
        run(2);

        // syscall -> handler
        issue(32'h00400100, 1, 0, 0, 0, 0);
        chk("sys_exc_pulse", 32'(bus.exception), 32'd1);
        chk("sys_cause", 32'(bus.cause), 32'd8);
        chk("sys_pc", bus.pc, 32'h00400104);
        run(F + 1);
        chk("sys_redirect_pc", bus.redirect_pc, 32'h00400004);
        step();
        chk("sys_in_handler", 32'(bus.in_handler), 32'd1);

        // second syscall in handler is ignored, then eret returns to EPC + 4
        issue(32'h00400200, 1, 0, 0, 0, 0);
        run(1);
        bus.epc = 32'h00400100;
        issue(32'h00400300, 0, 0, 0, 0, 1);
        chk("eret_pulse", 32'(bus.eret), 32'd1);
        run(F + 1);
        chk("eret_redirect_pc", bus.redirect_pc, 32'h00400104);
        step();
        chk("eret_cause_held", 32'(bus.cause), 32'd8);

        // eret in IDLE ignored; teq not taken, teq taken
        issue(32'h00400400, 0, 0, 0, 0, 1);
        issue(32'h00400410, 0, 0, 1, 0, 0);
        issue(32'h00400420, 0, 0, 1, 1, 0);
        chk("teq_cause", 32'(bus.cause), 32'd13);
        run(F + 3);
        // simultaneous trap + eret in handler: eret wins
        bus.epc = 32'h00400420;
        issue(32'h00400500, 1, 1, 0, 0, 1);
        chk("sim_eret", 32'(bus.eret), 32'd1);
        run(F + 3);

        // break, reset during flush, then break again
        issue(32'h00400600, 0, 1, 0, 0, 0);
        chk("brk_cause", 32'(bus.cause), 32'd9);
        step();
        async_reset();
        issue(32'h00400700, 0, 1, 0, 0, 0);
        chk("brk2_cause", 32'(bus.cause), 32'd9);
        run(F + 2);
        issue(32'h0, 0, 0, 0, 0, 1);
        run(F + 3);

        // status masking (syscall disabled, break enabled) and pc wrap
        bus.status = 32'h0000000D;
        issue(32'h00400800, 1, 0, 0, 0, 0);
        run(F + 3);
        issue(32'h0, 0, 0, 0, 0, 1);
        run(F + 3);
        issue(32'hFFFFFFFC, 0, 1, 0, 0, 0);
        chk("wrap_pc", bus.pc, 32'h00000000);
        run(F + 3);
        issue(32'h0, 0, 0, 0, 0, 1);
        run(F + 3);

        // random decode traffic
        for (int i = 0; i < 800; i++) begin
            bus.id_valid   = ($urandom_range(0, 3) != 0);
            bus.id_pc      = $urandom;
            bus.is_syscall = ($urandom_range(0, 9) == 0);
            bus.is_break   = ($urandom_range(0, 9) == 0);
            bus.is_teq     = ($urandom_range(0, 7) == 0);
            bus.teq_eq     = $urandom_range(0, 1);
            bus.is_eret    = ($urandom_range(0, 3) == 0);
            bus.status     = $urandom;
            if (m_pos < 0) bus.epc = $urandom;
            if ($urandom_range(0, 99) == 0) async_reset();
            else step();
        end

        idle_in();
        run(F + 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
